score_read_sequencer: RTL

Controller that walks the Needleman-Wunsch score matrix cell by cell and sequences the three score-RAM reads each cell needs. For every cell (i,j) it issues the diagonal, left and up neighbour addresses, drives `en_read`/`count` to the output manager aligned with the returned RAM data, and pulses `signal` so the manager presents diag/left/up to the processing element. It then waits for the PE to write the new score back before moving on. It sits between the score RAM read port and the output manager.

---
 rtl/nw_pkg.sv | 30 +++
 rtl/score_addr_gen.sv | 93 +++++++++
 rtl/score_read_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch score-matrix datapath.
//   DATA_W          : width of a score word held in the score RAM.
//   CNT_*           : neighbour codes sent to the output manager with each read.
//   SEL_*           : which neighbour address the address generator presents.
//   seq_state_t     : states of the read sequencer FSM.
package nw_pkg;

    localparam int DATA_W = 9;

    localparam logic [1:0] CNT_DIAG = 2'd0;
    localparam logic [1:0] CNT_LEFT = 2'd1;
    localparam logic [1:0] CNT_UP   = 2'd2;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_DIAG = 2'd1;
    localparam logic [1:0] SEL_LEFT = 2'd2;
    localparam logic [1:0] SEL_UP   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_DIAG,
        RD_LEFT,
        RD_UP,
        LAST,
        EMIT,
        WAIT_WR,
        FIN
    } seq_state_t;

endpackage

// File: rtl/score_addr_gen.sv
// Cell walker and neighbour address generator for the score matrix.
// Tracks the current cell (i,j) and the two row base addresses so that the
// neighbour addresses need only adders.
//   clk, rst   : clock, asynchronous active-high reset
//   init       : load cell (1,1)
//   advance    : step to the next cell in row-major order (not at the last cell)
//   sel        : SEL_* code choosing which address is driven on ram_addr
//   last_cell  : current cell is (N,N)
//   ram_addr   : selected neighbour address, 0 when sel is SEL_NONE
//   row, col   : current cell (i,j)
module score_addr_gen
    import nw_pkg::*;
#(
    parameter int N      = 2,
    parameter int ADDR_W = $clog2((N + 1) * (N + 1)),
    parameter int IDX_W  = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              advance,
    input  logic [1:0]        sel,
    output logic              last_cell,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [IDX_W-1:0]  row,
    output logic [IDX_W-1:0]  col
);

    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_N    = IDX_W'(N);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(N + 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [IDX_W-1:0]  i_q, i_d;
    logic [IDX_W-1:0]  j_q, j_d;
    // base_up = (i-1)(N+1), base_cur = i(N+1)
    logic [ADDR_W-1:0] base_up_q, base_up_d;
    logic [ADDR_W-1:0] base_cur_q, base_cur_d;
    logic [ADDR_W-1:0] j_ext;

    always_comb begin
        i_d        = i_q;
        j_d        = j_q;
        base_up_d  = base_up_q;
        base_cur_d = base_cur_q;
        if (init) begin
            i_d        = IDX_ONE;
            j_d        = IDX_ONE;
            base_up_d  = '0;
            base_cur_d = STRIDE;
        end else if (advance) begin
            if (j_q != IDX_N) begin
                j_d = j_q + IDX_ONE;
            end else begin
                // Row advance: slide both bases down one row.
                i_d        = i_q + IDX_ONE;
                j_d        = IDX_ONE;
                base_up_d  = base_cur_q;
                base_cur_d = base_cur_q + STRIDE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q        <= '0;
            j_q        <= '0;
            base_up_q  <= '0;
            base_cur_q <= '0;
        end else begin
            i_q        <= i_d;
            j_q        <= j_d;
            base_up_q  <= base_up_d;
            base_cur_q <= base_cur_d;
        end
    end

    assign j_ext = ADDR_W'(j_q);

    always_comb begin
        case (sel)
            SEL_DIAG: ram_addr = base_up_q + j_ext - ADDR_ONE;
            SEL_LEFT: ram_addr = base_cur_q + j_ext - ADDR_ONE;
            SEL_UP:   ram_addr = base_up_q + j_ext;
            default:  ram_addr = '0;
        endcase
    end

    assign last_cell = (i_q == IDX_N) && (j_q == IDX_N);
    assign row       = i_q;
    assign col       = j_q;

endmodule

// File: rtl/score_read_sequencer.sv
// Walks the (N+1)x(N+1) score matrix from (1,1) to (N,N), issuing the diag,
// left and up reads for each cell, forwarding read-valid and neighbour code
// to the output manager one cycle later (aligned with RAM data), pulsing
// signal once all three are captured, and waiting for the PE write-back.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin a full-matrix pass (honoured only in IDLE)
//   score_wr_done     : PE wrote score(i,j) (honoured only in WAIT_WR)
//   ram_en, ram_addr  : score RAM read port
//   en_read, count    : ram_data valid / neighbour code for the output manager
//   signal            : one-cycle pulse, present diag/left/up to the PE
//   row, col          : current cell
//   busy, done        : pass in progress / one-cycle completion pulse
module score_read_sequencer
    import nw_pkg::*;
#(
    parameter int N      = 2,
    parameter int ADDR_W = $clog2((N + 1) * (N + 1)),
    parameter int IDX_W  = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              score_wr_done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              en_read,
    output logic [1:0]        count,
    output logic              signal,
    output logic [IDX_W-1:0]  row,
    output logic [IDX_W-1:0]  col,
    output logic              busy,
    output logic              done
);

    seq_state_t state_q, state_d;
    logic       ram_en_q, ram_en_d;
    logic       signal_q, signal_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       en_read_q, en_read_d;
    logic [1:0] count_q, count_d;
    logic       init;
    logic       advance;
    logic       last_cell;
    logic [1:0] sel;

    always_comb begin
        state_d = state_q;
        init    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_DIAG;
                    init    = 1'b1;
                end
            end
            RD_DIAG: state_d = RD_LEFT;
            RD_LEFT: state_d = RD_UP;
            RD_UP:   state_d = LAST;
            LAST:    state_d = EMIT;
            EMIT:    state_d = WAIT_WR;
            WAIT_WR: begin
                if (score_wr_done) begin
                    if (last_cell) begin
                        state_d = FIN;
                    end else begin
                        state_d = RD_DIAG;
                        advance = 1'b1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they flop with it.
        ram_en_d = (state_d == RD_DIAG) || (state_d == RD_LEFT) || (state_d == RD_UP);
        signal_d = (state_d == EMIT);
        done_d   = (state_d == FIN);
        busy_d   = (state_d != IDLE);

        // One-cycle pipeline matching the RAM read latency; count holds when idle.
        en_read_d = ram_en_q;
        count_d   = count_q;
        if (ram_en_q) begin
            case (state_q)
                RD_DIAG: count_d = CNT_DIAG;
                RD_LEFT: count_d = CNT_LEFT;
                RD_UP:   count_d = CNT_UP;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ram_en_q  <= 1'b0;
            signal_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            en_read_q <= 1'b0;
            count_q   <= CNT_DIAG;
        end else begin
            state_q   <= state_d;
            ram_en_q  <= ram_en_d;
            signal_q  <= signal_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            en_read_q <= en_read_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        case (state_q)
            RD_DIAG: sel = SEL_DIAG;
            RD_LEFT: sel = SEL_LEFT;
            RD_UP:   sel = SEL_UP;
            default: sel = SEL_NONE;
        endcase
    end

    score_addr_gen #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .advance   (advance),
        .sel       (sel),
        .last_cell (last_cell),
        .ram_addr  (ram_addr),
        .row       (row),
        .col       (col)
    );

    assign ram_en  = ram_en_q;
    assign signal  = signal_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign en_read = en_read_q;
    assign count   = count_q;

endmodule
